uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and default widths for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_TMOWIDTH  = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the arbiter, grouped with directional modports.
interface uart_tx_arbiter_if #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4
) ();

  // Handshake: a requester raises req[i] with stable data and holds both until
  // ack[i] pulses for one cycle. tx_valid is a one-cycle launch strobe; the
  // transmitter answers by raising tx_busy for the frame and dropping it when done.
  logic [NREQ-1:0]           req;
  logic [NREQ*DATAWIDTH-1:0] req_data;
  logic                      cfg_par_en;
  logic                      cfg_par_typ;
  logic                      tx_busy;
  logic [NREQ-1:0]           ack;
  logic [DATAWIDTH-1:0]      tx_data;
  logic                      tx_valid;
  logic                      tx_par_en;
  logic                      tx_par_typ;
  logic                      err_tmo;

  modport master (
    input  req, req_data, cfg_par_en, cfg_par_typ, tx_busy,
    output ack, tx_data, tx_valid, tx_par_en, tx_par_typ, err_tmo
  );

  modport slave (
    output req, req_data, cfg_par_en, cfg_par_typ, tx_busy,
    input  ack, tx_data, tx_valid, tx_par_en, tx_par_typ, err_tmo
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping to index 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Upper segment [ptr..NREQ-1] first, then the wrapped segment [0..ptr-1].
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (PW'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (PW'(i) < ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = PW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NREQ byte requesters,
// with a timeout on the transmitter's busy acknowledge.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int TMOWIDTH  = DEF_TMOWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus,
  output state_t            dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  // Timeout fires on the edge where the counter would reach its all-ones value.
  localparam logic [TMOWIDTH-1:0] TMO_LAST = TMOWIDTH'((1 << TMOWIDTH) - 2);

  state_t               state, state_nx;
  logic [PW-1:0]        rr_ptr;
  logic [NREQ-1:0]      pick_oh;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic [DATAWIDTH-1:0] pick_byte;
  logic [NREQ-1:0]      win_oh;
  logic [DATAWIDTH-1:0] data_q;
  logic                 par_en_q;
  logic                 par_typ_q;
  logic [TMOWIDTH-1:0]  tmo_cnt;
  logic                 tmo_hit;
  logic                 grant_now;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_byte = pick_byte | bus.req_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  assign tmo_hit   = (state == WAIT_BUSY) && !bus.tx_busy && (tmo_cnt == TMO_LAST);
  assign grant_now = (state == IDLE) && pick_any && !bus.tx_busy;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (grant_now) state_nx = LAUNCH;
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)  state_nx = WAIT_DONE;
        else if (tmo_hit) state_nx = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      win_oh    <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_now) begin
        win_oh    <= pick_oh;
        data_q    <= pick_byte;
        par_en_q  <= bus.cfg_par_en;
        par_typ_q <= bus.cfg_par_typ;
        rr_ptr    <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
      end
      if ((state == WAIT_BUSY) && (state_nx == WAIT_BUSY)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                                 tmo_cnt <= '0;
    end
  end

  assign bus.tx_valid   = (state == LAUNCH);
  assign bus.ack        = (state == LAUNCH) ? win_oh : '0;
  assign bus.tx_data    = data_q;
  assign bus.tx_par_en  = par_en_q;
  assign bus.tx_par_typ = par_typ_q;
  assign bus.err_tmo    = tmo_hit;
  assign dbg_state      = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected launches are queued by the driver
// and checked by an independent negedge monitor.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int W  = NR + DW + 2;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  uart_tx_arbiter_if #(.DATAWIDTH(DW), .NREQ(NR)) bus ();

  uart_tx_arbiter #(.DATAWIDTH(DW), .NREQ(NR), .TMOWIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_tmo_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int launch_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] pack(input logic [NR-1:0] a, input logic [DW-1:0] d,
                                        input logic pe, input logic pt);
    return {a, d, pe, pt};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [7:0]   t;
    if (rst) begin
      cyc++;
      if (bus.tx_valid) begin
        launch_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_launch", 32'(bus.ack), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("ack",        32'(bus.ack),        32'(e[W-1 -: NR]));
          check("tx_data",    32'(bus.tx_data),    32'(e[DW+1:2]));
          check("tx_par_en",  32'(bus.tx_par_en),  32'(e[1]));
          check("tx_par_typ", 32'(bus.tx_par_typ), 32'(e[0]));
        end
      end
      if (bus.err_tmo) begin
        if (exp_tmo_q.size() == 0) begin
          check("unexpected_err_tmo", 32'(bus.err_tmo), 32'h0);
        end else begin
          t = exp_tmo_q.pop_front();
          check("err_tmo_delay", 32'(cyc - launch_cyc), 32'(t));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_launch(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'h1);
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (dbg_state == IDLE) seen = 1'b1;
    end
    check(name, 32'(seen), 32'h1);
  endtask

  // Called at the negedge of the launch cycle: the acked requester drops its bit,
  // the transmitter raises busy one cycle after tx_valid and holds it busy_len cycles.
  task automatic serve(input int busy_len, input bit toggle_cfg, input logic pe_exp,
                       input logic pt_exp);
    logic [NR-1:0] a;
    a = bus.ack;
    @(posedge clk); #1;
    bus.req     = bus.req & ~a;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      @(posedge clk); #1;
      if (toggle_cfg && i == 0) begin
        bus.cfg_par_en  = ~bus.cfg_par_en;
        bus.cfg_par_typ = ~bus.cfg_par_typ;
      end
    end
    if (toggle_cfg) begin
      check("par_en_hold",  32'(bus.tx_par_en),  32'(pe_exp));
      check("par_typ_hold", 32'(bus.tx_par_typ), 32'(pt_exp));
    end
    bus.tx_busy = 1'b0;
    @(posedge clk); #1;
    check("idle_after_busy", 32'(dbg_state), 32'(IDLE));
    check("no_ack_after_busy", 32'(bus.ack), 32'h0);
  endtask

  task automatic set_byte(input int i, input logic [DW-1:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int quiet;
    rst = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.cfg_par_en = 1'b0;
    bus.cfg_par_typ = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",    32'(dbg_state),     32'(IDLE));
    check("rst_ack",      32'(bus.ack),       32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid),  32'h0);
    check("rst_tx_data",  32'(bus.tx_data),   32'h0);
    check("rst_err_tmo",  32'(bus.err_tmo),   32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // single requester, busy rises one cycle after tx_valid
    set_byte(0, 8'hA5);
    bus.cfg_par_en = 1'b1;
    bus.cfg_par_typ = 1'b0;
    exp_q.push_back(pack(4'b0001, 8'hA5, 1'b1, 1'b0));
    bus.req = 4'b0001;
    wait_launch("launch_single");
    serve(3, 1'b0, 1'b0, 1'b0);

    // fresh pointer, all four persistent: rotation 0,1,2,3
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
    bus.cfg_par_en = 1'b0;
    bus.cfg_par_typ = 1'b1;
    exp_q.push_back(pack(4'b0001, 8'h11, 1'b0, 1'b1));
    exp_q.push_back(pack(4'b0010, 8'h22, 1'b0, 1'b1));
    exp_q.push_back(pack(4'b0100, 8'h33, 1'b0, 1'b1));
    exp_q.push_back(pack(4'b1000, 8'h44, 1'b0, 1'b1));
    @(posedge clk); #1;
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_launch("launch_rotate");
      serve(2, 1'b0, 1'b0, 1'b0);
    end

    // transmitter never acknowledges: timeout 7 cycles after launch
    set_byte(1, 8'h5A);
    bus.cfg_par_en = 1'b1;
    bus.cfg_par_typ = 1'b1;
    exp_q.push_back(pack(4'b0010, 8'h5A, 1'b1, 1'b1));
    exp_tmo_q.push_back(8'd7);
    bus.req = 4'b0010;
    wait_launch("launch_tmo");
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(negedge clk);
    wait_idle("idle_after_tmo");
    set_byte(3, 8'hC3);
    exp_q.push_back(pack(4'b1000, 8'hC3, 1'b1, 1'b1));
    @(posedge clk); #1;
    bus.req = 4'b1000;
    wait_launch("launch_after_tmo");
    serve(2, 1'b0, 1'b0, 1'b0);

    // busy in IDLE blocks the grant
    set_byte(2, 8'h77);
    bus.tx_busy = 1'b1;
    bus.req = 4'b0100;
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.tx_valid || (bus.ack != 4'b0000)) quiet++;
    end
    check("no_grant_while_busy", 32'(quiet), 32'h0);
    exp_q.push_back(pack(4'b0100, 8'h77, 1'b1, 1'b1));
    @(posedge clk); #1;
    bus.tx_busy = 1'b0;
    wait_launch("launch_after_busy");
    serve(2, 1'b0, 1'b0, 1'b0);

    // cfg toggled during WAIT_DONE must not touch the byte in flight
    set_byte(0, 8'h3C);
    bus.cfg_par_en = 1'b1;
    bus.cfg_par_typ = 1'b1;
    exp_q.push_back(pack(4'b0001, 8'h3C, 1'b1, 1'b1));
    bus.req = 4'b0001;
    wait_launch("launch_cfg");
    serve(3, 1'b1, 1'b1, 1'b1);

    // reset during WAIT_DONE: outputs clear, pointer restarts at 0
    set_byte(1, 8'h96);
    set_byte(2, 8'h69);
    bus.cfg_par_en = 1'b0;
    bus.cfg_par_typ = 1'b1;
    exp_q.push_back(pack(4'b0010, 8'h96, 1'b0, 1'b1));
    bus.req = 4'b0110;
    wait_launch("launch_pre_rst");
    @(posedge clk); #1;
    bus.req = bus.req & ~bus.ack;
    bus.req = 4'b0100;
    bus.tx_busy = 1'b1;
    @(posedge clk); #1;
    check("in_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    rst = 1'b0;
    #1;
    check("mrst_state",      32'(dbg_state),      32'(IDLE));
    check("mrst_ack",        32'(bus.ack),        32'h0);
    check("mrst_tx_valid",   32'(bus.tx_valid),   32'h0);
    check("mrst_tx_data",    32'(bus.tx_data),    32'h0);
    check("mrst_tx_par_en",  32'(bus.tx_par_en),  32'h0);
    check("mrst_tx_par_typ", 32'(bus.tx_par_typ), 32'h0);
    check("mrst_err_tmo",    32'(bus.err_tmo),    32'h0);
    bus.tx_busy = 1'b0;
    set_byte(0, 8'h5E);
    bus.req = 4'b0101;
    bus.cfg_par_en = 1'b1;
    bus.cfg_par_typ = 1'b0;
    exp_q.push_back(pack(4'b0001, 8'h5E, 1'b1, 1'b0));
    exp_q.push_back(pack(4'b0100, 8'h69, 1'b1, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    wait_launch("launch_post_rst_lowest");
    serve(2, 1'b0, 1'b0, 1'b0);
    wait_launch("launch_post_rst_next");
    serve(2, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("exp_q_drained",     32'(exp_q.size()),     32'h0);
    check("exp_tmo_q_drained", 32'(exp_tmo_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
